// File: rtl/servo_sched_pkg.sv
// rtl/servo_sched_pkg.sv - shared widths, FSM state codes, pose type and clamp helper
package servo_sched_pkg;

  localparam int SERVO_W = 13;
  localparam int CNT_W   = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RAMP  = 3'd2;
  localparam logic [2:0] ST_DWELL = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  typedef struct packed {
    logic [SERVO_W-1:0] ch3;
    logic [SERVO_W-1:0] ch2;
    logic [SERVO_W-1:0] ch1;
    logic [SERVO_W-1:0] ch0;
  } pose_t;

  function automatic logic [SERVO_W-1:0] clamp(input logic [SERVO_W-1:0] x,
                                               input logic [SERVO_W-1:0] lo,
                                               input logic [SERVO_W-1:0] hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

endpackage

// File: rtl/servo_slew_step.sv
// rtl/servo_slew_step.sv - one bounded slew step of a servo channel toward its target
module servo_slew_step
  import servo_sched_pkg::*;
(
  input  logic [SERVO_W-1:0] current,
  input  logic [SERVO_W-1:0] target,
  input  logic [SERVO_W-1:0] step,
  output logic [SERVO_W-1:0] next,
  output logic               at_target
);

  logic signed [SERVO_W:0] diff;
  logic signed [SERVO_W:0] step_s;

  always_comb begin
    diff      = $signed({1'b0, target}) - $signed({1'b0, current});
    step_s    = $signed({1'b0, step});
    at_target = (diff == '0);
    if (diff > step_s)       next = current + step;
    else if (diff < -step_s) next = current - step;
    else                     next = target;
  end

endmodule

// File: rtl/servo_replay_scheduler.sv
// rtl/servo_replay_scheduler.sv - manual pass-through or record/replay of servo poses; REPLAY_LOOP_EN repeats replay until stopped
module servo_replay_scheduler
  import servo_sched_pkg::*;
#(
  parameter int                 DEPTH       = 16,
  parameter int                 TICK_DIV    = 50000,
  parameter logic [SERVO_W-1:0] STEP        = 13'd20,
  parameter int                 DWELL_TICKS = 500,
  parameter logic [SERVO_W-1:0] SERVO_MIN   = 13'd500,
  parameter logic [SERVO_W-1:0] SERVO_MAX   = 13'd2500
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SERVO_W-1:0] i_manual0,
  input  logic [SERVO_W-1:0] i_manual1,
  input  logic [SERVO_W-1:0] i_manual2,
  input  logic [SERVO_W-1:0] i_manual3,
  input  logic               i_record,
  input  logic               i_play,
  input  logic               i_stop,
  input  logic               i_clear,
  output logic [SERVO_W-1:0] o_servo0,
  output logic [SERVO_W-1:0] o_servo1,
  output logic [SERVO_W-1:0] o_servo2,
  output logic [SERVO_W-1:0] o_servo3,
  output logic               o_replaying,
  output logic [CNT_W-1:0]   o_tot_state,
  output logic [CNT_W-1:0]   o_current_state,
  output logic               o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [2:0]         state;
  logic [CNT_W-1:0]   tot, idx;
  logic [TW-1:0]      tick_cnt;
  logic [DW-1:0]      dwell_cnt;
  pose_t              mem [DEPTH];
  pose_t              tgt, manual_pose;
  logic [SERVO_W-1:0] servo [4];
  logic [SERVO_W-1:0] man [4];
  logic [SERVO_W-1:0] tgt_ch [4];
  logic [SERVO_W-1:0] nxt [4];
  logic [3:0]         at_tgt;
  logic               tick, full, mem_we, last_pose;

  assign man[0] = clamp(i_manual0, SERVO_MIN, SERVO_MAX);
  assign man[1] = clamp(i_manual1, SERVO_MIN, SERVO_MAX);
  assign man[2] = clamp(i_manual2, SERVO_MIN, SERVO_MAX);
  assign man[3] = clamp(i_manual3, SERVO_MIN, SERVO_MAX);
  assign manual_pose = {man[3], man[2], man[1], man[0]};

  assign tgt_ch[0] = tgt.ch0;
  assign tgt_ch[1] = tgt.ch1;
  assign tgt_ch[2] = tgt.ch2;
  assign tgt_ch[3] = tgt.ch3;

  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign full      = (tot == DEPTH_C);
  assign last_pose = (({1'b0, idx} + 1'b1) >= {1'b0, tot});
  // Record only wins when no higher-priority command shares the cycle.
  assign mem_we    = !i_rst && (state == ST_IDLE) && i_record && !i_stop &&
                     !i_clear && !i_play && !full;

  for (genvar k = 0; k < 4; k++) begin : g_slew
    servo_slew_step u_step (
      .current  (servo[k]),
      .target   (tgt_ch[k]),
      .step     (STEP),
      .next     (nxt[k]),
      .at_target(at_tgt[k])
    );
  end

  // Pose RAM: the target register doubles as the synchronous read port.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[tot[AW-1:0]] <= manual_pose;
    if (state == ST_LOAD) tgt <= mem[idx[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      tot       <= '0;
      idx       <= '0;
      tick_cnt  <= '0;
      dwell_cnt <= '0;
      for (int k = 0; k < 4; k++) servo[k] <= SERVO_MIN;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (state != ST_IDLE && i_stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            for (int k = 0; k < 4; k++) servo[k] <= man[k];
            if (!i_stop) begin
              if (i_clear) tot <= '0;
              else if (i_play) begin
                if (tot != '0) begin
                  idx   <= '0;
                  state <= ST_LOAD;
                end
              end else if (i_record && !full) tot <= tot + 1'b1;
            end
          end
          ST_LOAD: begin
            tick_cnt <= '0;
            state    <= ST_RAMP;
          end
          ST_RAMP: begin
            if (tick) begin
              for (int k = 0; k < 4; k++) servo[k] <= nxt[k];
              if (&at_tgt) begin
                dwell_cnt <= '0;
                state     <= ST_DWELL;
              end
            end
          end
          ST_DWELL: begin
            if (tick) begin
              if (dwell_cnt == DW'(DWELL_TICKS - 1)) begin
                if (last_pose) state <= ST_END;
                else begin
                  idx   <= idx + 1'b1;
                  state <= ST_LOAD;
                end
              end else dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          ST_END: begin
`ifdef REPLAY_LOOP_EN
            idx   <= '0;
            state <= ST_LOAD;
`else
            state <= ST_IDLE;
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_servo0        = servo[0];
  assign o_servo1        = servo[1];
  assign o_servo2        = servo[2];
  assign o_servo3        = servo[3];
  assign o_replaying     = (state != ST_IDLE);
  assign o_current_state = o_replaying ? idx : '0;
  assign o_tot_state     = tot;
  assign o_full          = full;

endmodule

// File: tb/tb_servo_replay_scheduler.sv
// tb/tb_servo_replay_scheduler.sv - directed self-checking bench for servo_replay_scheduler
module tb_servo_replay_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] m0, m1, m2, m3;
  logic        rec, play, stop, clr;
  logic [12:0] s0, s1, s2, s3;
  logic        rep;
  logic [4:0]  tot, cur;
  logic        full;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  servo_replay_scheduler #(
    .DEPTH(4), .TICK_DIV(4), .STEP(13'd20), .DWELL_TICKS(2),
    .SERVO_MIN(13'd500), .SERVO_MAX(13'd2500)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_manual0(m0), .i_manual1(m1), .i_manual2(m2), .i_manual3(m3),
    .i_record(rec), .i_play(play), .i_stop(stop), .i_clear(clr),
    .o_servo0(s0), .o_servo1(s1), .o_servo2(s2), .o_servo3(s3),
    .o_replaying(rep), .o_tot_state(tot), .o_current_state(cur), .o_full(full)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_manual(input logic [12:0] a, input logic [12:0] b,
                            input logic [12:0] c, input logic [12:0] d);
    m0 = a; m1 = b; m2 = c; m3 = d;
  endtask

  task automatic pulse_rec();
    rec = 1'b1; cyc(1); rec = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1; cyc(1); play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(1); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(2);
    checks++;
    if (s0 !== 13'd500 || s1 !== 13'd500 || s2 !== 13'd500 || s3 !== 13'd500) begin
      errors++; $display("FAIL reset_servo: got %0d %0d %0d %0d expected 500 each", s0, s1, s2, s3);
    end
    checks++;
    if (rep !== 1'b0 || tot !== 5'd0 || cur !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got rep=%0b tot=%0d cur=%0d full=%0b expected 0 0 0 0", rep, tot, cur, full);
    end
    rst = 1'b0;
  endtask

  task automatic test_clamp();
    set_manual(13'd3000, 13'd100, 13'd1500, 13'd2500); cyc(1);
    checks++;
    if (s0 !== 13'd2500 || s1 !== 13'd500 || s2 !== 13'd1500 || s3 !== 13'd2500) begin
      errors++; $display("FAIL clamp: got %0d %0d %0d %0d expected 2500 500 1500 2500", s0, s1, s2, s3);
    end
    checks++;
    if (rep !== 1'b0) begin
      errors++; $display("FAIL clamp_rep: got %0b expected 0", rep);
    end
  endtask

  task automatic test_record_replay();
    logic [12:0] exp_v;
    set_manual(13'd1000, 13'd1000, 13'd1000, 13'd1000); pulse_rec();
    set_manual(13'd1040, 13'd960, 13'd1000, 13'd1000); pulse_rec();
    checks++;
    if (tot !== 5'd2) begin
      errors++; $display("FAIL rec_tot: got %0d expected 2", tot);
    end
    set_manual(13'd500, 13'd500, 13'd500, 13'd500); cyc(1);
    pulse_play();
    checks++;
    if (rep !== 1'b1 || cur !== 5'd0 || s0 !== 13'd500) begin
      errors++; $display("FAIL play_start: got rep=%0b cur=%0d s0=%0d expected 1 0 500", rep, cur, s0);
    end
    for (int k = 1; k <= 25; k++) begin
      cyc((k == 1) ? 5 : 4);
      exp_v = 13'(500 + 20 * k);
      checks++;
      if (s0 !== exp_v || s1 !== exp_v || s3 !== exp_v) begin
        errors++; $display("FAIL ramp_step%0d: got %0d %0d %0d expected %0d", k, s0, s1, s3, exp_v);
      end
    end
    cyc(11);
    checks++;
    if (cur !== 5'd0 || s0 !== 13'd1000) begin
      errors++; $display("FAIL dwell0: got cur=%0d s0=%0d expected 0 1000", cur, s0);
    end
    cyc(1);
    checks++;
    if (cur !== 5'd1) begin
      errors++; $display("FAIL next_pose: got cur=%0d expected 1", cur);
    end
    cyc(5);
    checks++;
    if (s0 !== 13'd1020 || s1 !== 13'd980) begin
      errors++; $display("FAIL pose1_tick1: got %0d %0d expected 1020 980", s0, s1);
    end
    cyc(4);
    checks++;
    if (s0 !== 13'd1040 || s1 !== 13'd960) begin
      errors++; $display("FAIL pose1_tick2: got %0d %0d expected 1040 960", s0, s1);
    end
    cyc(12);
    checks++;
    if (rep !== 1'b1) begin
      errors++; $display("FAIL end_state: got rep=%0b expected 1", rep);
    end
    cyc(1);
`ifdef REPLAY_LOOP_EN
    checks++;
    if (rep !== 1'b1 || cur !== 5'd0) begin
      errors++; $display("FAIL loop_wrap: got rep=%0b cur=%0d expected 1 0", rep, cur);
    end
    pulse_stop();
    checks++;
    if (rep !== 1'b0) begin
      errors++; $display("FAIL loop_stop: got rep=%0b expected 0", rep);
    end
    cyc(1);
`else
    checks++;
    if (rep !== 1'b0 || s0 !== 13'd1040) begin
      errors++; $display("FAIL idle_return: got rep=%0b s0=%0d expected 0 1040", rep, s0);
    end
    cyc(1);
    checks++;
    if (s0 !== 13'd500 || s1 !== 13'd500) begin
      errors++; $display("FAIL idle_manual: got %0d %0d expected 500 500", s0, s1);
    end
`endif
  endtask

  task automatic test_stop_with_play();
    pulse_play(); cyc(3);
    play = 1'b1; stop = 1'b1; cyc(1); play = 1'b0; stop = 1'b0;
    checks++;
    if (rep !== 1'b0 || tot !== 5'd2) begin
      errors++; $display("FAIL stop_play: got rep=%0b tot=%0d expected 0 2", rep, tot);
    end
    cyc(1);
    checks++;
    if (rep !== 1'b0) begin
      errors++; $display("FAIL stop_play_hold: got rep=%0b expected 0", rep);
    end
  endtask

  task automatic test_clear();
    pulse_play(); cyc(3);
    pulse_clr();
    checks++;
    if (tot !== 5'd2 || rep !== 1'b1) begin
      errors++; $display("FAIL clear_in_ramp: got tot=%0d rep=%0b expected 2 1", tot, rep);
    end
    pulse_stop();
    pulse_clr();
    checks++;
    if (tot !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL clear_idle: got tot=%0d full=%0b expected 0 0", tot, full);
    end
  endtask

  task automatic test_play_empty();
    pulse_play();
    checks++;
    if (rep !== 1'b0) begin
      errors++; $display("FAIL play_empty: got rep=%0b expected 0", rep);
    end
    cyc(2);
    checks++;
    if (rep !== 1'b0 || cur !== 5'd0) begin
      errors++; $display("FAIL play_empty_hold: got rep=%0b cur=%0d expected 0 0", rep, cur);
    end
  endtask

  task automatic test_full();
    bit seen;
    set_manual(13'd500, 13'd500, 13'd500, 13'd500);
    pulse_rec(); pulse_rec(); pulse_rec();
    set_manual(13'd520, 13'd500, 13'd500, 13'd500); pulse_rec();
    set_manual(13'd700, 13'd500, 13'd500, 13'd500); pulse_rec();
    checks++;
    if (tot !== 5'd4 || full !== 1'b1) begin
      errors++; $display("FAIL full: got tot=%0d full=%0b expected 4 1", tot, full);
    end
    set_manual(13'd500, 13'd500, 13'd500, 13'd500); cyc(1);
    pulse_play();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc(1);
      if (cur === 5'd3) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reach_idx3: got cur=%0d expected 3 within 200 cycles", cur);
    end
    cyc(12);
    checks++;
    if (s0 !== 13'd520 || cur !== 5'd3) begin
      errors++; $display("FAIL pose3_kept: got s0=%0d cur=%0d expected 520 3", s0, cur);
    end
    pulse_stop();
  endtask

  task automatic test_reset_in_dwell();
    pulse_clr();
    set_manual(13'd500, 13'd500, 13'd500, 13'd500); cyc(1);
    pulse_rec();
    pulse_play();
    set_manual(13'd2000, 13'd2000, 13'd2000, 13'd2000);
    cyc(7);
    checks++;
    if (rep !== 1'b1 || s0 !== 13'd500) begin
      errors++; $display("FAIL dwell_hold: got rep=%0b s0=%0d expected 1 500", rep, s0);
    end
    rst = 1'b1; cyc(1); rst = 1'b0;
    checks++;
    if (s0 !== 13'd500 || s3 !== 13'd500 || rep !== 1'b0 || tot !== 5'd0 || cur !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL rst_dwell: got s0=%0d s3=%0d rep=%0b tot=%0d cur=%0d full=%0b expected 500 500 0 0 0 0", s0, s3, rep, tot, cur, full);
    end
    cyc(1);
    checks++;
    if (s0 !== 13'd2000) begin
      errors++; $display("FAIL post_rst_manual: got %0d expected 2000", s0);
    end
  endtask

`ifdef REPLAY_LOOP_EN
  task automatic test_loop();
    int         seq[$];
    logic [4:0] last;
    bit         dropped;
    set_manual(13'd500, 13'd500, 13'd500, 13'd500); cyc(1);
    pulse_rec(); pulse_rec();
    pulse_play();
    dropped = 1'b0;
    seq.push_back(int'(cur));
    last = cur;
    for (int i = 0; i < 300 && seq.size() < 4; i++) begin
      cyc(1);
      if (rep !== 1'b1) dropped = 1'b1;
      if (cur !== last) begin
        seq.push_back(int'(cur));
        last = cur;
      end
    end
    checks++;
    if (seq.size() != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
      errors++; $display("FAIL loop_seq: got %0d entries expected sequence 0,1,0,1", seq.size());
    end
    checks++;
    if (dropped) begin
      errors++; $display("FAIL loop_rep: got replaying drop expected steady 1");
    end
    pulse_stop();
    checks++;
    if (rep !== 1'b0) begin
      errors++; $display("FAIL loop_end_stop: got rep=%0b expected 0", rep);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; rec = 1'b0; play = 1'b0; stop = 1'b0; clr = 1'b0;
    set_manual(13'd0, 13'd0, 13'd0, 13'd0);
    test_reset();
    test_clamp();
    test_record_replay();
    test_stop_with_play();
    test_clear();
    test_play_empty();
    test_full();
    test_reset_in_dwell();
`ifdef REPLAY_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
